reg_write_arbitration: RTL

Write-back end of the register file, the counterpart of the operand read path.
- Owns the 16 x 32-bit general registers r00..r15 and the 16-bit hold scoreboard hold_Q.
- Accepts results from two write-back sources (A = ALU, B = memory unit) and arbitrates them onto the single register write port, one write per cycle, round-robin.
- Sets hold bits when the issue stage reserves a destination, and clears them when the result is written back.
- Register and hold outputs feed the operand read path directly.

---
 rtl/reg_write_arbitration.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reg_write_arbitration.sv
// Write-back end of the register file: 16 x 32-bit registers, hold scoreboard,
// and a round-robin arbiter merging two write-back sources onto one write port.
module reg_write_arbitration #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [3:0]  issue_dest,
    output logic        issue_ready,
    input  logic        wbA_valid,
    input  logic [3:0]  wbA_dest,
    input  logic [31:0] wbA_data,
    output logic        wbA_ready,
    input  logic        wbB_valid,
    input  logic [3:0]  wbB_dest,
    input  logic [31:0] wbB_data,
    output logic        wbB_ready,
    output logic [31:0] r00_Q,
    output logic [31:0] r01_Q,
    output logic [31:0] r02_Q,
    output logic [31:0] r03_Q,
    output logic [31:0] r04_Q,
    output logic [31:0] r05_Q,
    output logic [31:0] r06_Q,
    output logic [31:0] r07_Q,
    output logic [31:0] r08_Q,
    output logic [31:0] r09_Q,
    output logic [31:0] r10_Q,
    output logic [31:0] r11_Q,
    output logic [31:0] r12_Q,
    output logic [31:0] r13_Q,
    output logic [31:0] r14_Q,
    output logic [31:0] r15_Q,
    output logic [15:0] hold_Q,
    output logic [4:0]  outstanding,
    output logic        wb_err,
    input  logic        err_clr
);

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_e;

    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [15:0] hold_q, hold_d;
    logic [4:0]  outstanding_q, outstanding_d;
    logic        wb_err_q, wb_err_d;
    pri_e        ptr_q, ptr_d;

    logic        grant_a, grant_b, wr_en, issue_fire;
    logic [3:0]  wr_dest;
    logic [31:0] wr_data;

    // The pointer only breaks ties; a lone valid source is always granted.
    assign grant_a    = wbA_valid & (~wbB_valid | (ptr_q == PRI_A));
    assign grant_b    = wbB_valid & (~wbA_valid | (ptr_q == PRI_B));
    assign wbA_ready  = grant_a;
    assign wbB_ready  = grant_b;
    assign wr_en      = grant_a | grant_b;
    assign wr_dest    = grant_a ? wbA_dest : wbB_dest;
    assign wr_data    = grant_a ? wbA_data : wbB_data;

    // Registered hold bit only, so a same-cycle write-back cannot unblock a WAW.
    assign issue_ready = ~hold_q[issue_dest];
    assign issue_fire  = issue_valid & issue_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        regs_d   = regs_q;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        wb_err_d = wb_err_q & ~err_clr;
        if (wr_en) begin
            regs_d[wr_dest] = wr_data;
            hold_d[wr_dest] = 1'b0;
            if (!hold_q[wr_dest])
                wb_err_d = 1'b1;
        end
        if (issue_fire)
            hold_d[issue_dest] = 1'b1;
        if (wbA_valid && wbB_valid)
            ptr_d = (ptr_q == PRI_A) ? PRI_B : PRI_A;
        outstanding_d = 5'($countones(hold_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register array is reset because readers rely on RESET_VALUE;
            // a plain RAM would normally be left unreset.
            for (int i = 0; i < 16; i++)
                regs_q[i] <= RESET_VALUE;
            hold_q        <= '0;
            outstanding_q <= '0;
            wb_err_q      <= 1'b0;
            ptr_q         <= PRI_A;
        end else begin
            // NOTE: state updates use non-blocking assignment so all flops see pre-edge values.
            regs_q        <= regs_d;
            hold_q        <= hold_d;
            outstanding_q <= outstanding_d;
            wb_err_q      <= wb_err_d;
            ptr_q         <= ptr_d;
        end
    end

    assign hold_Q      = hold_q;
    assign outstanding = outstanding_q;
    assign wb_err      = wb_err_q;
    assign r00_Q = regs_q[0];
    assign r01_Q = regs_q[1];
    assign r02_Q = regs_q[2];
    assign r03_Q = regs_q[3];
    assign r04_Q = regs_q[4];
    assign r05_Q = regs_q[5];
    assign r06_Q = regs_q[6];
    assign r07_Q = regs_q[7];
    assign r08_Q = regs_q[8];
    assign r09_Q = regs_q[9];
    assign r10_Q = regs_q[10];
    assign r11_Q = regs_q[11];
    assign r12_Q = regs_q[12];
    assign r13_Q = regs_q[13];
    assign r14_Q = regs_q[14];
    assign r15_Q = regs_q[15];

endmodule
